// File: rtl/ascii_text_loader.sv
// ascii_text_loader: buffers hps_io "Load Ascii" bytes, normalises CR/LF and paces them into the ACIA.
// Optional: define ASCII_TEXT_LOADER_UPCASE_EN to fold a-z to A-Z before buffering.
module ascii_text_loader #(
  parameter int DEPTH      = 16,
  parameter int CHAR_DELAY = 48000,
  parameter int LINE_DELAY = 4800000
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [15:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  output logic        ioctl_wait,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ack,
  output logic        loading,
  output logic        overflow
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int DMAX = (CHAR_DELAY > LINE_DELAY) ? CHAR_DELAY : LINE_DELAY;
  localparam int DW   = (DMAX > 0) ? $clog2(DMAX + 1) : 1;
  localparam logic [DW-1:0] CHAR_LOAD = DW'((CHAR_DELAY > 0) ? CHAR_DELAY - 1 : 0);
  localparam logic [DW-1:0] LINE_LOAD = DW'((LINE_DELAY > 0) ? LINE_DELAY - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   delay_q, delay_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_addr;
  logic            prev_cr_q, prev_cr_d, overflow_q, overflow_d;
  logic            dl_q, wait_q, rx_valid_q, rx_valid_d;
  logic [7:0]      rx_data_q;
  logic [7:0]      mem [DEPTH];

  logic            start, prev_cr_eff, drop, accept, wr_en, pop, full;
  logic [7:0]      store_byte;

  assign start = ioctl_download & ~dl_q;

  // Input filter: the first byte of a file never sees a stale CR from the previous one.
  always_comb begin
    prev_cr_eff = prev_cr_q;
    if (start || ioctl_addr == 16'd0) prev_cr_eff = 1'b0;
    drop   = (ioctl_data == 8'h00) || (ioctl_data == 8'h1A) ||
             ((ioctl_data == 8'h0A) && prev_cr_eff);
    accept = ioctl_wr && ioctl_download && !drop;
    store_byte = (ioctl_data == 8'h0A) ? 8'h0D : ioctl_data;
`ifdef ASCII_TEXT_LOADER_UPCASE_EN
    if (store_byte >= 8'h61 && store_byte <= 8'h7A) store_byte = store_byte - 8'h20;
`endif
    prev_cr_d = start ? 1'b0 : prev_cr_q;
    if (accept) prev_cr_d = (ioctl_data == 8'h0D);
  end

  // FIFO bookkeeping; a flush cycle still accepts its own byte into slot 0.
  always_comb begin
    full       = (count_q == CW'(DEPTH));
    wr_en      = accept && (start || !full || pop);
    wr_addr    = start ? '0 : wr_ptr_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (start) begin
      count_d    = wr_en ? CW'(1) : '0;
      wr_ptr_d   = wr_en ? AW'(1) : '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (accept && full && !pop) overflow_d = 1'b1;
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_en && !pop)      count_d = count_q + CW'(1);
      else if (pop && !wr_en) count_d = count_q - CW'(1);
    end
  end

  // Output FSM: next state
  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    if (start) begin
      state_d = S_IDLE;
      delay_d = '0;
    end else begin
      case (state_q)
        S_IDLE:    if (count_q != '0) state_d = S_PRESENT;
        S_PRESENT: if (rx_ack) begin
          state_d = S_GAP;
          delay_d = (rx_data_q == 8'h0D) ? LINE_LOAD : CHAR_LOAD;
        end
        S_GAP:     if (delay_q == '0) state_d = S_IDLE;
                   else delay_d = delay_q - 1'b1;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Output FSM: pop and presentation control
  always_comb begin
    pop        = 1'b0;
    rx_valid_d = rx_valid_q;
    if (start) begin
      rx_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (count_q != '0) begin
          pop        = 1'b1;
          rx_valid_d = 1'b1;
        end
        S_PRESENT: if (rx_ack) rx_valid_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= S_IDLE;
      delay_q    <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      prev_cr_q  <= 1'b0;
      overflow_q <= 1'b0;
      dl_q       <= 1'b0;
      wait_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      delay_q    <= delay_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      prev_cr_q  <= prev_cr_d;
      overflow_q <= overflow_d;
      dl_q       <= ioctl_download;
      wait_q     <= (count_q >= CW'(DEPTH - 2));
      rx_valid_q <= rx_valid_d;
      if (pop) rx_data_q <= mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= store_byte;
  end

  assign ioctl_wait = wait_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign overflow   = overflow_q;
  assign loading    = n_reset & (ioctl_download | (count_q != '0) | (state_q != S_IDLE));

endmodule

// File: tb/tb_ascii_text_loader.sv
// Scoreboard bench for ascii_text_loader with DEPTH=8, CHAR_DELAY=3, LINE_DELAY=10.
module tb_ascii_text_loader;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [15:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        ioctl_wait;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ack = 1'b0;
  logic        loading;
  logic        overflow;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  int          gap_q[$];
  logic        m_prev_cr;
  logic [15:0] m_addr;

  ascii_text_loader #(.DEPTH(DEPTH), .CHAR_DELAY(3), .LINE_DELAY(10)) dut (
    .clk(clk), .n_reset(n_reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wait(ioctl_wait),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack), .loading(loading),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Drop download for a cycle and raise it again; the caller's next send lands in the edge cycle.
  task automatic begin_file();
    ioctl_download = 1'b0;
    @(posedge clk); #1;
    ioctl_download = 1'b1;
    m_prev_cr = 1'b0;
    m_addr = '0;
    exp_q.delete();
    gap_q.delete();
  endtask

  // Drive one ioctl byte and push the character the loader should deliver for it.
  task automatic send(input logic [7:0] b);
    logic [7:0] s;
    if (!(b == 8'h00 || b == 8'h1A || (b == 8'h0A && m_prev_cr))) begin
      m_prev_cr = (b == 8'h0D);
      s = (b == 8'h0A) ? 8'h0D : b;
`ifdef ASCII_TEXT_LOADER_UPCASE_EN
      if (s >= 8'h61 && s <= 8'h7A) s = s - 8'h20;
`endif
      exp_q.push_back(s);
    end
    ioctl_wr = 1'b1;
    ioctl_data = b;
    ioctl_addr = m_addr;
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
    m_addr = m_addr + 16'd1;
  endtask

  // Consume n characters, acking each at once; gap_q[i] = cycles waited before char i.
  task automatic drain(input int n);
    int waited;
    logic [7:0] exp;
    for (int i = 0; i < n; i++) begin
      waited = 0;
      while (rx_valid !== 1'b1 && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      gap_q.push_back(waited);
      checks++;
      if (rx_valid !== 1'b1) begin
        errors++;
        $display("FAIL rx_timeout: rx_valid=%b required 1 within 200 cycles", rx_valid);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_extra: rx_data=%02h required no character", rx_data);
      end else begin
        exp = exp_q.pop_front();
        $display("char %0d: rx_data=%02h expected=%02h gap=%0d", i, rx_data, exp, waited);
        if (rx_data !== exp) begin
          errors++;
          $display("FAIL rx_data: got %02h required %02h", rx_data, exp);
        end
        rx_ack = 1'b1;
        @(posedge clk); #1;
        rx_ack = 1'b0;
      end
    end
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (rx_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL %s: rx_valid high for %0d cycles required 0", name, seen);
    end
  endtask

  task automatic test_reset();
    #3;
    checks += 5;
    if (rx_data !== 8'h00)  begin errors++; $display("FAIL reset_rx_data: got %02h required 00", rx_data); end
    if (rx_valid !== 1'b0)  begin errors++; $display("FAIL reset_rx_valid: got %b required 0", rx_valid); end
    if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL reset_wait: got %b required 0", ioctl_wait); end
    if (loading !== 1'b0)   begin errors++; $display("FAIL reset_loading: got %b required 0", loading); end
    if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow: got %b required 0", overflow); end
    @(posedge clk); #1;
    n_reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    begin_file();
    send(8'h41); send(8'h0D); send(8'h0A); send(8'h42);
    drain(3);
    checks += 2;
    if (gap_q.size() < 3 || gap_q[1] != 5) begin
      errors++; $display("FAIL char_gap: got %0d required 5", (gap_q.size() > 1) ? gap_q[1] : -1);
    end
    if (gap_q.size() < 3 || gap_q[2] != 12) begin
      errors++; $display("FAIL line_gap: got %0d required 12", (gap_q.size() > 2) ? gap_q[2] : -1);
    end
    ioctl_download = 1'b0;
    expect_quiet("basic_extra", 20);
    checks++;
    if (loading !== 1'b0) begin errors++; $display("FAIL loading_idle: got %b required 0", loading); end
  endtask

  task automatic test_filter();
    begin_file();
    send(8'h0A); send(8'h00); send(8'h1A); send(8'h5A);
    drain(2);
    expect_quiet("filter_extra", 20);
  endtask

  task automatic test_overflow();
    int prev_cnt = 0;
    int cnt;
    logic exp_wait;
    begin_file();
    for (int k = 1; k <= 10; k++) begin
      send(8'h2F + 8'(k));
      // Char 1 is popped on the cycle write 2 lands, so occupancy is 1,1,2,3,... capped at DEPTH.
      cnt = (k == 1) ? 1 : ((k - 1 > DEPTH) ? DEPTH : k - 1);
      exp_wait = (prev_cnt >= DEPTH - 2);
      checks++;
      if (ioctl_wait !== exp_wait) begin
        errors++; $display("FAIL ioctl_wait_w%0d: got %b required %b", k, ioctl_wait, exp_wait);
      end
      prev_cnt = cnt;
    end
    void'(exp_q.pop_back());  // write 10 arrives with the FIFO full and no pop
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b required 1", overflow); end
  endtask

  task automatic test_flush();
    int waited = 0;
    drain(2);
    while (rx_valid !== 1'b1 && waited < 50) begin @(negedge clk); waited++; end
    checks++;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid: got %b required 1", rx_valid); end
    ioctl_download = 1'b0;
    @(posedge clk); #1;
    ioctl_download = 1'b1;
    @(posedge clk); #1;
    checks += 2;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL flush_rx_valid: got %b required 0", rx_valid); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL flush_overflow: got %b required 0", overflow); end
    @(posedge clk); #1;
    checks += 2;
    if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL flush_wait: got %b required 0", ioctl_wait); end
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL flush_empty: got rx_valid %b required 0", rx_valid); end
    exp_q.delete();
    m_prev_cr = 1'b0;
    m_addr = '0;
    send(8'h51);
    drain(1);
    expect_quiet("flush_extra", 20);
  endtask

  task automatic test_reset_gap();
    int waited = 0;
    begin_file();
    send(8'h48); send(8'h49); send(8'h4A); send(8'h4B); send(8'h4C);
    while (rx_valid !== 1'b1 && waited < 50) begin @(negedge clk); waited++; end
    rx_ack = 1'b1;
    @(posedge clk); #1;
    rx_ack = 1'b0;
    #2;
    n_reset = 1'b0;
    #1;
    checks += 4;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_gap_rx_data: got %02h required 00", rx_data); end
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_gap_rx_valid: got %b required 0", rx_valid); end
    if (loading !== 1'b0)  begin errors++; $display("FAIL rst_gap_loading: got %b required 0", loading); end
    if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL rst_gap_wait: got %b required 0", ioctl_wait); end
    ioctl_download = 1'b0;
    @(posedge clk); #1;
    n_reset = 1'b1;
    expect_quiet("rst_gap_stale", 30);
    checks++;
    if (loading !== 1'b0) begin errors++; $display("FAIL rst_gap_idle_loading: got %b required 0", loading); end
    begin_file();
    send(8'h4D);
    drain(1);
  endtask

  task automatic test_case();
    begin_file();
    send(8'h70); send(8'h72); send(8'h69); send(8'h6E); send(8'h74);
    drain(5);
    expect_quiet("case_extra", 10);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_filter();
    test_overflow();
    test_flush();
    test_reset_gap();
    test_case();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascii_text_loader.md
Name: ascii_text_loader

Overview:
- Sits between the hps_io ioctl download port and the UK101 ACIA receive path.
- Buffers bytes of a "Load Ascii" file (TXT/BAS/LOD) in a small FIFO and normalises line endings.
- Presents one character at a time to the ACIA receive register, paced so BASIC/monitor can tokenise each line.
- Throttles hps_io through ioctl_wait.

Parameters:
- DEPTH, 16: FIFO depth in bytes. Power of two, at least 4.
- CHAR_DELAY, 48000: idle clk cycles after each character is consumed (1 ms at 48 MHz).
- LINE_DELAY, 4800000: idle clk cycles after a consumed 0x0D (100 ms at 48 MHz).

Ports:
- clk  in  1  system clock (48 MHz).
- n_reset  in  1  asynchronous active-low reset.
- ioctl_download  in  1  download in progress (from hps_io).
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  16  byte address. Used only to detect the first byte (address 0).
- ioctl_data  in  8  download byte.
- ioctl_wait  out  1  stall request to hps_io.
- rx_data  out  8  character presented to the ACIA.
- rx_valid  out  1  character available (drives ACIA RDRF).
- rx_ack  in  1  one-cycle pulse when the CPU reads the ACIA data register.
- loading  out  1  high while a download is active or characters remain.
- overflow  out  1  sticky flag: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (n_reset=0, asynchronous):
  - FIFO empty, state IDLE.
  - rx_data=0x00, rx_valid=0, ioctl_wait=0, loading=0, overflow=0, prev_cr=0, delay counter=0.
- Download start (rising edge of ioctl_download, registered):
  - Flushes the FIFO, clears overflow and prev_cr, drops rx_valid, forces IDLE, cancels any pending delay.
  - A byte written in the same cycle as the edge is accepted after the flush.
- Input filter, applied on ioctl_wr with ioctl_download=1:
  - 0x00 and 0x1A are dropped.
  - 0x0A with prev_cr=1 is dropped.
  - 0x0A with prev_cr=0 is stored as 0x0D.
  - Any other byte is stored unchanged.
  - prev_cr is set when the raw byte is 0x0D and cleared by any other non-dropped byte.
- FIFO:
  - Synchronous. Count width is clog2(DEPTH)+1.
  - Push and pop in the same cycle leave the count unchanged.
  - A push when count==DEPTH (with no simultaneous pop) is discarded and sets overflow=1.
  - Read and write pointers wrap modulo DEPTH.
- ioctl_wait is registered: 1 when count >= DEPTH-2, giving two slots of margin for in-flight writes.
- Output FSM:
  - IDLE: if FIFO is non-empty, pop. Next cycle rx_data=popped byte, rx_valid=1, go to PRESENT. One-cycle latency from non-empty to rx_valid.
  - PRESENT: hold rx_data and rx_valid until rx_ack. On rx_ack, next cycle rx_valid=0. Load the counter with LINE_DELAY-1 if rx_data==0x0D, else CHAR_DELAY-1. Go to GAP.
  - GAP: decrement each cycle; at 0 go to IDLE. The next rx_valid therefore rises no earlier than delay+2 cycles after rx_ack.
  - rx_ack outside PRESENT is ignored.
- The delay counter is sized to clog2(max(CHAR_DELAY, LINE_DELAY)+1) bits. Delays of 0 are legal; GAP then lasts one cycle.
- loading = ioctl_download | (count!=0) | (state!=IDLE).
- Falling ioctl_download does not flush; buffered characters drain normally.
- Reset during any state returns all outputs to their reset values within the same cycle (asynchronous).

Optional Feature:
- Macro: ASCII_TEXT_LOADER_UPCASE_EN.
- Defined: the filter maps 0x61–0x7A to 0x41–0x5A before storing, so lowercase listings load into UK101 BASIC. The mapping is applied after CR/LF handling.
- Undefined: bytes pass unchanged apart from the CR/LF, 0x00 and 0x1A rules.

Test Plan:
- Bench parameters for all scenarios: DEPTH=8, CHAR_DELAY=3, LINE_DELAY=10.
- Write "A",0x0D,0x0A,"B", ack each char immediately:
  - Expected sequence 0x41,0x0D,0x42.
  - Gap between ack of 0x41 and next rx_valid is 5 cycles; after ack of 0x0D it is 12 cycles.
- Write 0x0A alone, then 0x00, then 0x1A, then "Z" -> outputs 0x0D,0x5A only.
- Hold rx_ack=0 and write 10 bytes back-to-back:
  - ioctl_wait rises the cycle after count reaches 6.
  - Bytes 10 (and 9 if a pop has not occurred) are dropped; overflow=1.
- Mid-drain with rx_valid=1, pulse ioctl_download 0->1 -> rx_valid=0 next cycle, FIFO empty, overflow=0, the new file's first byte appears.
- Assert n_reset=0 in GAP with 4 bytes buffered -> all outputs 0 immediately; after release, no output until a new ioctl_wr.
- With ASCII_TEXT_LOADER_UPCASE_EN: write "print" -> outputs 0x50,0x52,0x49,0x4E,0x54. Without it: 0x70,0x72,0x69,0x6E,0x74.
